// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aud_pkg
//  Brief    : Shared audio-path types and constants (player / recorder).
//  Revision : 1.0 - initial release
// ============================================================================
package aud_pkg;

    localparam int   AUD_DATA_W = 16;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2,
        S_PAD  = 2'd3
    } aud_state_e;

endpackage
`default_nettype wire

// File: rtl/aud_i2s_player_if.sv
`default_nettype none
// ============================================================================
//  Module   : aud_i2s_player_if
//  Brief    : DSP-side sample bus and codec-side I2S pins of the player.
//  Revision : 1.0 - initial release
// ============================================================================
interface aud_i2s_player_if
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W
);
    logic              i_en;
    logic              i_daclrck;
    logic [DATA_W-1:0] i_dac_data;
    logic              o_aud_dacdat;
    logic              o_sample_req;
    logic              o_busy;
    logic              o_short_err;

    modport master (
        output i_en, i_daclrck, i_dac_data,
        input  o_aud_dacdat, o_sample_req, o_busy, o_short_err
    );

    modport slave (
        input  i_en, i_daclrck, i_dac_data,
        output o_aud_dacdat, o_sample_req, o_busy, o_short_err
    );
endinterface
`default_nettype wire

// File: rtl/aud_lrck_edge.sv
`default_nettype none
// ============================================================================
//  Module   : aud_lrck_edge
//  Brief    : Registers codec LRCK on BCLK falling edge, flags channel starts.
//  Revision : 1.0 - initial release
// ============================================================================
module aud_lrck_edge
    import aud_pkg::*;
(
    input  wire logic i_clk,
    input  wire logic i_rst,
    input  wire logic i_lrck,
    output logic      o_left_start,
    output logic      o_right_start
);

    logic r_lrck_q;

    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lrck_q <= LRCK_LEFT;
        end else begin
            r_lrck_q <= i_lrck;
        end
    end

    // Starts are combinational so the consumer can act on the detecting edge.
    assign o_left_start  = (r_lrck_q == LRCK_RIGHT) && (i_lrck == LRCK_LEFT);
    assign o_right_start = (r_lrck_q == LRCK_LEFT)  && (i_lrck == LRCK_RIGHT);

endmodule
`default_nettype wire

// File: rtl/aud_i2s_player.sv
`default_nettype none
// ============================================================================
//  Module   : aud_i2s_player
//  Brief    : Serialises DSP samples MSB-first onto WM8731 DACDAT (I2S).
//  Revision : 1.0 - initial release
// ============================================================================
module aud_i2s_player
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W,
    parameter bit MONO   = 1'b1
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    aud_i2s_player_if.slave bus
);

    localparam int                 c_CNT_W     = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_START = c_CNT_W'(DATA_W - 2);

    aud_state_e          r_state;
    aud_state_e          w_state_nxt;
    logic [DATA_W-1:0]   r_hold;
    logic [DATA_W-1:0]   w_hold_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                r_dacdat;
    logic                w_dacdat_nxt;
    logic                r_sample_req;
    logic                w_sample_req_nxt;
    logic                r_short_err;
    logic                w_short_err_nxt;

    logic                w_left_start;
    logic                w_right_start;
    logic [DATA_W-1:0]   w_right_word;

    aud_lrck_edge u_lrck_edge (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_lrck        (bus.i_daclrck),
        .o_left_start  (w_left_start),
        .o_right_start (w_right_start)
    );

    // Right channel source: repeat the held left sample or take a fresh one.
    generate
        if (MONO) begin : g_mono
            assign w_right_word = r_hold;
        end else begin : g_stereo
            assign w_right_word = bus.i_dac_data;
        end
    endgenerate

    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold;
        w_cnt_nxt        = r_cnt;
        w_dacdat_nxt     = 1'b0;
        w_sample_req_nxt = 1'b0;
        w_short_err_nxt  = r_short_err;

        case (r_state)
            S_IDLE: begin
                if (bus.i_en) begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (!bus.i_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_left_start) begin
                    w_hold_nxt       = bus.i_dac_data;
                    w_dacdat_nxt     = bus.i_dac_data[DATA_W-1];
                    w_cnt_nxt        = c_CNT_START;
                    w_sample_req_nxt = 1'b1;
                    w_state_nxt      = S_SEND;
                end
            end

            S_SEND, S_PAD: begin
                if (w_left_start || w_right_start) begin
                    // A start while bits remain means the channel was too short.
                    if (r_state == S_SEND) begin
                        w_short_err_nxt = 1'b1;
                    end
                    if (w_right_start) begin
                        w_hold_nxt   = w_right_word;
                        w_dacdat_nxt = w_right_word[DATA_W-1];
                        w_cnt_nxt    = c_CNT_START;
                        w_state_nxt  = S_SEND;
                    end else if (bus.i_en) begin
                        w_hold_nxt       = bus.i_dac_data;
                        w_dacdat_nxt     = bus.i_dac_data[DATA_W-1];
                        w_cnt_nxt        = c_CNT_START;
                        w_sample_req_nxt = 1'b1;
                        w_state_nxt      = S_SEND;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_state == S_SEND) begin
                    w_dacdat_nxt = r_hold[r_cnt];
                    if (r_cnt == '0) begin
                        w_state_nxt = S_PAD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold       <= '0;
            r_cnt        <= '0;
            r_dacdat     <= 1'b0;
            r_sample_req <= 1'b0;
            r_short_err  <= 1'b0;
        end else begin
            r_hold       <= w_hold_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dacdat     <= w_dacdat_nxt;
            r_sample_req <= w_sample_req_nxt;
            r_short_err  <= w_short_err_nxt;
        end
    end

    assign bus.o_aud_dacdat = r_dacdat;
    assign bus.o_sample_req = r_sample_req;
    assign bus.o_busy       = (r_state != S_IDLE);
    assign bus.o_short_err  = r_short_err;

endmodule
`default_nettype wire
